// File: rtl/frame_sync_detector.sv
// Frame synchroniser: hunts for a 32-bit attached sync marker in a word stream,
// confirms it over LOCK_THRESH frames, then forwards payload words and flags each
// frame boundary to the downstream de-interleaver. Lock is held through up to
// UNLOCK_THRESH-1 consecutive corrupted markers (flywheel).
// Optional build macro FRAME_SYNC_STATS_EN adds frame and lock-loss counters.
module frame_sync_detector #(
    parameter logic [31:0] SYNC_WORD     = 32'h1ACFFC1D,
    parameter int unsigned PAYLOAD_WORDS = 280,
    parameter int unsigned LOCK_THRESH   = 2,
    parameter int unsigned UNLOCK_THRESH = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        sync_reset_o,
`ifdef FRAME_SYNC_STATS_EN
    output logic [15:0] frame_cnt_o,
    output logic [15:0] lock_loss_cnt_o,
`endif
    output logic        locked_o
);

    localparam int unsigned CntW = $clog2(PAYLOAD_WORDS + 1);
    localparam logic [CntW-1:0] SlotIdx = CntW'(PAYLOAD_WORDS);
    localparam logic [3:0] LockTh   = 4'(LOCK_THRESH);
    localparam logic [3:0] UnlockTh = 4'(UNLOCK_THRESH);

    typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] word_cnt_q, word_cnt_d;
    logic [3:0]      hit_q, hit_d;
    logic [3:0]      miss_q, miss_d;

    logic        m_valid_q;
    logic [31:0] m_data_q;
    logic        sync_q, sync_d;
    logic        locked_q;

    logic beat_acc;
    logic fwd;
    logic is_slot;
    logic is_match;

    // In SEARCH the counter is always 0, so is_slot only matters in VERIFY/LOCKED.
    assign is_slot  = (word_cnt_q == SlotIdx);
    assign is_match = (s_axis_tdata == SYNC_WORD);

    // State and frame counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StSearch;
            word_cnt_q <= '0;
            hit_q      <= '0;
            miss_q     <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
        end
    end

    // Next-state: marker hunting, verification and flywheel lock maintenance
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        hit_d      = hit_q;
        miss_d     = miss_q;
        if (beat_acc) begin
            unique case (state_q)
                StSearch: begin
                    if (is_match) begin
                        word_cnt_d = '0;
                        hit_d      = 4'd1;
                        miss_d     = '0;
                        state_d    = (LockTh == 4'd1) ? StLocked : StVerify;
                    end
                end
                StVerify: begin
                    if (!is_slot) begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end else begin
                        word_cnt_d = '0;
                        if (is_match) begin
                            hit_d = hit_q + 4'd1;
                            if (hit_q + 4'd1 == LockTh) begin
                                state_d = StLocked;
                                miss_d  = '0;
                            end
                        end else begin
                            state_d = StSearch;
                            hit_d   = '0;
                        end
                    end
                end
                StLocked: begin
                    if (!is_slot) begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end else begin
                        word_cnt_d = '0;
                        if (is_match) begin
                            miss_d = '0;
                        end else if (miss_q + 4'd1 == UnlockTh) begin
                            state_d = StSearch;
                            hit_d   = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + 4'd1;
                        end
                    end
                end
                default: state_d = StSearch;
            endcase
        end
    end

    // Outputs: handshake, forwarding decision and frame-boundary pulse
    always_comb begin
        s_axis_tready = !m_valid_q || m_axis_tready;
        beat_acc      = s_axis_tvalid && s_axis_tready;
        fwd           = beat_acc && (state_q == StLocked) && !is_slot;
        // Pulse only for a marker that matched and leaves us LOCKED.
        sync_d = beat_acc && is_match &&
                 (((state_q == StSearch) && (LockTh == 4'd1)) ||
                  ((state_q == StVerify) && is_slot && (hit_q + 4'd1 == LockTh)) ||
                  ((state_q == StLocked) && is_slot));
    end

    // Output register slice plus registered status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            sync_q    <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            if (fwd) begin
                m_valid_q <= 1'b1;
                m_data_q  <= s_axis_tdata;
            end else if (m_axis_tready) begin
                m_valid_q <= 1'b0;
            end
            sync_q   <= sync_d;
            locked_q <= (state_d == StLocked);
        end
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign sync_reset_o  = sync_q;
    assign locked_o      = locked_q;

`ifdef FRAME_SYNC_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] loss_cnt_q;

    // Saturating statistics counters
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            loss_cnt_q  <= '0;
        end else begin
            if (sync_d && (frame_cnt_q != 16'hFFFF)) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if ((state_q == StLocked) && (state_d == StSearch) && (loss_cnt_q != 16'hFFFF)) begin
                loss_cnt_q <= loss_cnt_q + 16'd1;
            end
        end
    end

    assign frame_cnt_o     = frame_cnt_q;
    assign lock_loss_cnt_o = loss_cnt_q;
`endif

endmodule
